// File: rtl/key_process_pkg.sv
// Shared constants and helpers for the key_process debouncer.
package key_process_pkg;

  localparam int SYNC_DEPTH = 2;

  // Width needed to hold values 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_sync.sv
// N-flop level synchronizer for one asynchronous input bit, with a
// configurable reset level.
module key_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {N{RST_VAL}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/key_process.sv
// Push-button debouncer: synchronizer, stable-level counter and press/release
// pulse generator. Define KEY_PROCESS_REPEAT_EN to add auto-repeat on key_en.
module key_process
  import key_process_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 100,
  parameter logic KEY_ACTIVE      = 1'b1
`ifdef KEY_PROCESS_REPEAT_EN
  ,
  parameter int   REPEAT_DELAY    = 500,
  parameter int   REPEAT_PERIOD   = 100
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_en,
  output logic key_rel,
  output logic key_state
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_out;
  logic          key_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          en_q, en_d;
  logic          rel_q, rel_d;
  logic          press;
  logic          rep_fire;

  key_sync #(
    .N       (SYNC_DEPTH),
    .RST_VAL (~KEY_ACTIVE)
  ) u_key_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (key),
    .q_o    (sync_out)
  );

  // Normalized: 1 means pressed regardless of pin polarity.
  assign key_s = (sync_out == KEY_ACTIVE);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    press   = 1'b0;
    rel_d   = 1'b0;
    if (key_s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = key_s;
      cnt_d   = '0;
      press   = key_s;
      rel_d   = ~key_s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

`ifdef KEY_PROCESS_REPEAT_EN
  localparam int             RW       = cnt_width(REPEAT_DELAY);
  localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  REP_WRAP = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rep_q, rep_d;

  // Runs only while the key stays pressed across this edge, so a repeat can
  // never coincide with the press or release pulse.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q && state_d) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
        rep_d    = REP_WRAP;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign en_d = press | rep_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      en_q    <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      en_q    <= en_d;
      rel_q   <= rel_d;
    end
  end

  assign key_en    = en_q;
  assign key_rel   = rel_q;
  assign key_state = state_q;

endmodule

// File: tb/tb_key_process.sv
// Directed bench for key_process: debounce latency, glitch rejection, reset,
// active-low pin and (when KEY_PROCESS_REPEAT_EN is defined) auto-repeat.
module tb_key_process;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key_a = 1'b0;
  logic key_b = 1'b1;
  logic key_en_a, key_rel_a, key_state_a;
  logic key_en_b, key_rel_b, key_state_b;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int last0_a  = 0;
  int both_hi  = 0;

  logic [31:0] en_a_q[$];
  logic [31:0] rel_a_q[$];
  logic [31:0] en_b_q[$];
  logic [31:0] rel_b_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  key_process dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key_a),
    .key_en    (key_en_a),
    .key_rel   (key_rel_a),
    .key_state (key_state_a)
  );

  key_process #(.KEY_ACTIVE(1'b0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key_b),
    .key_en    (key_en_b),
    .key_rel   (key_rel_b),
    .key_state (key_state_b)
  );

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    if (key_a == 1'b0) last0_a = edge_cnt;
  end

  always @(negedge clk) begin
    if (key_en_a)  en_a_q.push_back(32'(edge_cnt));
    if (key_rel_a) rel_a_q.push_back(32'(edge_cnt));
    if (key_en_b)  en_b_q.push_back(32'(edge_cnt));
    if (key_rel_b) rel_b_q.push_back(32'(edge_cnt));
    if ((key_en_a && key_rel_a) || (key_en_b && key_rel_b)) both_hi = both_hi + 1;
  end

`ifdef KEY_PROCESS_REPEAT_EN
  logic key_c = 1'b0;
  logic key_en_c, key_rel_c, key_state_c;
  logic [31:0] en_c_q[$];
  logic [31:0] rel_c_q[$];

  key_process #(.REPEAT_DELAY(50), .REPEAT_PERIOD(20)) dut_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key_c),
    .key_en    (key_en_c),
    .key_rel   (key_rel_c),
    .key_state (key_state_c)
  );

  always @(negedge clk) begin
    if (key_en_c)  en_c_q.push_back(32'(edge_cnt));
    if (key_rel_c) rel_c_q.push_back(32'(edge_cnt));
  end
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    en_a_q.delete();
    rel_a_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(4);
    total++;
    if (key_state_a !== 1'b0) begin bad++; $display("FAIL reset_state_a: got %b want 0", key_state_a); end
    total++;
    if (key_en_a !== 1'b0 || key_rel_a !== 1'b0) begin
      bad++; $display("FAIL reset_pulses_a: got en=%b rel=%b want 0 0", key_en_a, key_rel_a);
    end
    total++;
    if (key_state_b !== 1'b0 || key_en_b !== 1'b0 || key_rel_b !== 1'b0) begin
      bad++; $display("FAIL reset_b: got st=%b en=%b rel=%b want 0 0 0", key_state_b, key_en_b, key_rel_b);
    end
    rst_n = 1'b1;
    step(5);
  endtask

  task automatic test_burst_press();
    clear_a();
    for (int i = 0; i < 30; i++) begin
      key_a = 1'b0;
      #13;
      key_a = 1'b1;
      #12;
    end
    total++;
    if (en_a_q.size() != 0) begin bad++; $display("FAIL burst_no_en: got %0d pulses want 0", en_a_q.size()); end
    step(400);
    total++;
    if (en_a_q.size() != 1) begin
      bad++; $display("FAIL burst_en_count: got %0d want 1", en_a_q.size());
    end else begin
      total++;
      if (en_a_q[0] != 32'(last0_a + 102)) begin
        bad++; $display("FAIL burst_en_edge: got %0d want %0d", en_a_q[0], last0_a + 102);
      end
    end
    total++;
    if (key_state_a !== 1'b1) begin bad++; $display("FAIL burst_state: got %b want 1", key_state_a); end
    total++;
    if (rel_a_q.size() != 0) begin bad++; $display("FAIL burst_no_rel: got %0d want 0", rel_a_q.size()); end
  endtask

  task automatic test_release();
    int e;
    clear_a();
    key_a = 1'b0;
    e = edge_cnt;
    step(200);
    total++;
    if (rel_a_q.size() != 1) begin
      bad++; $display("FAIL release_count: got %0d want 1", rel_a_q.size());
    end else begin
      total++;
      if (rel_a_q[0] != 32'(e + 102)) begin
        bad++; $display("FAIL release_edge: got %0d want %0d", rel_a_q[0], e + 102);
      end
    end
    total++;
    if (en_a_q.size() != 0) begin bad++; $display("FAIL release_no_en: got %0d want 0", en_a_q.size()); end
    total++;
    if (key_state_a !== 1'b0) begin bad++; $display("FAIL release_state: got %b want 0", key_state_a); end
  endtask

  task automatic test_threshold();
    int e;
    clear_a();
    key_a = 1'b1;
    step(99);
    key_a = 1'b0;
    step(150);
    total++;
    if (en_a_q.size() != 0 || rel_a_q.size() != 0) begin
      bad++; $display("FAIL short99_pulses: got en=%0d rel=%0d want 0 0", en_a_q.size(), rel_a_q.size());
    end
    total++;
    if (key_state_a !== 1'b0) begin bad++; $display("FAIL short99_state: got %b want 0", key_state_a); end
    clear_a();
    key_a = 1'b1;
    e = edge_cnt;
    step(100);
    key_a = 1'b0;
    step(150);
    total++;
    if (en_a_q.size() != 1) begin
      bad++; $display("FAIL exact100_en_count: got %0d want 1", en_a_q.size());
    end else begin
      total++;
      if (en_a_q[0] != 32'(e + 102)) begin
        bad++; $display("FAIL exact100_en_edge: got %0d want %0d", en_a_q[0], e + 102);
      end
    end
    total++;
    if (rel_a_q.size() != 1) begin
      bad++; $display("FAIL exact100_rel_count: got %0d want 1", rel_a_q.size());
    end else begin
      total++;
      if (rel_a_q[0] != 32'(e + 202)) begin
        bad++; $display("FAIL exact100_rel_edge: got %0d want %0d", rel_a_q[0], e + 202);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    int r;
    clear_a();
    key_a = 1'b1;
    step(62);
    rst_n = 1'b0;
    step(3);
    total++;
    if (key_state_a !== 1'b0 || key_en_a !== 1'b0) begin
      bad++; $display("FAIL midreset_hold: got st=%b en=%b want 0 0", key_state_a, key_en_a);
    end
    rst_n = 1'b1;
    r = edge_cnt;
    step(150);
    total++;
    if (en_a_q.size() != 1) begin
      bad++; $display("FAIL midreset_en_count: got %0d want 1", en_a_q.size());
    end else begin
      total++;
      if (en_a_q[0] != 32'(r + 102)) begin
        bad++; $display("FAIL midreset_en_edge: got %0d want %0d", en_a_q[0], r + 102);
      end
    end
    total++;
    if (key_state_a !== 1'b1) begin bad++; $display("FAIL midreset_state: got %b want 1", key_state_a); end
    key_a = 1'b0;
    step(200);
    total++;
    if (rel_a_q.size() != 1) begin bad++; $display("FAIL midreset_rel: got %0d want 1", rel_a_q.size()); end
  endtask

  task automatic test_active_low();
    int e;
    en_b_q.delete();
    rel_b_q.delete();
    key_b = 1'b0;
    e = edge_cnt;
    step(300);
    total++;
    if (en_b_q.size() != 1) begin
      bad++; $display("FAIL actlow_en_count: got %0d want 1", en_b_q.size());
    end else begin
      total++;
      if (en_b_q[0] != 32'(e + 102)) begin
        bad++; $display("FAIL actlow_en_edge: got %0d want %0d", en_b_q[0], e + 102);
      end
    end
    total++;
    if (key_state_b !== 1'b1) begin bad++; $display("FAIL actlow_state_pressed: got %b want 1", key_state_b); end
    key_b = 1'b1;
    e = edge_cnt;
    step(200);
    total++;
    if (rel_b_q.size() != 1) begin
      bad++; $display("FAIL actlow_rel_count: got %0d want 1", rel_b_q.size());
    end else begin
      total++;
      if (rel_b_q[0] != 32'(e + 102)) begin
        bad++; $display("FAIL actlow_rel_edge: got %0d want %0d", rel_b_q[0], e + 102);
      end
    end
    total++;
    if (key_state_b !== 1'b0 || en_b_q.size() != 1) begin
      bad++; $display("FAIL actlow_after_rel: got st=%b en=%0d want 0 1", key_state_b, en_b_q.size());
    end
  endtask

`ifdef KEY_PROCESS_REPEAT_EN
  task automatic test_repeat();
    int e;
    int p;
    en_c_q.delete();
    rel_c_q.delete();
    exp_q.delete();
    key_c = 1'b1;
    e = edge_cnt;
    p = e + 102;
    exp_q.push_back(32'(p));
    for (int t = 50; t <= 190; t += 20) exp_q.push_back(32'(p + t));
    // Pin released so the debounced release lands at p+201.
    step(201);
    key_c = 1'b0;
    step(250);
    total++;
    if (en_c_q.size() != exp_q.size()) begin
      bad++; $display("FAIL repeat_count: got %0d want %0d", en_c_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (en_c_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL repeat_edge%0d: got %0d want %0d", i, en_c_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if (rel_c_q.size() != 1 || key_state_c !== 1'b0) begin
      bad++; $display("FAIL repeat_release: got rel=%0d st=%b want 1 0", rel_c_q.size(), key_state_c);
    end
  endtask
`endif

  task automatic test_exclusive();
    total++;
    if (both_hi != 0) begin bad++; $display("FAIL en_rel_overlap: got %0d cycles want 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_burst_press();
    test_release();
    test_threshold();
    test_reset_mid_count();
    test_active_low();
`ifdef KEY_PROCESS_REPEAT_EN
    test_repeat();
`endif
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_process.md
Name: key_process

Overview:
- Debounces one mechanical push-button input and emits single-cycle event pulses for a clean press and a clean release.
- Sits between an FPGA pin (asynchronous, bouncing) and control logic that consumes one strobe per press.
- Contains a 2-FF synchronizer, a stable-level counter and an edge/event generator.

Parameters:
- DEBOUNCE_CYCLES, 100: consecutive clock cycles the synchronized input must hold a new level before it is accepted; legal range >= 2.
- KEY_ACTIVE, 1: raw pin level that means "pressed" (1 = active-high, 0 = active-low).
- REPEAT_DELAY, 500: cycles from the press pulse to the first auto-repeat pulse; used only with the optional feature.
- REPEAT_PERIOD, 100: cycles between subsequent auto-repeat pulses; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- key  input  1  raw asynchronous button pin.
- key_en  output  1  one-cycle pulse on each accepted press (and on auto-repeat when enabled).
- key_rel  output  1  one-cycle pulse on each accepted release.
- key_state  output  1  debounced level; 1 = pressed, independent of KEY_ACTIVE.

Behaviour:
- One clock domain. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values:
  - both sync flops load the released level (~KEY_ACTIVE);
  - key_state = 0, counter = 0, key_en = 0, key_rel = 0, repeat counter = 0.
- Synchronizer: two flops. key_s = (sync2 == KEY_ACTIVE), so key_s is normalized with pressed = 1.
- Counter width is clog2(DEBOUNCE_CYCLES+1).
- Counter rules, applied each edge:
  - key_s == key_state: counter is cleared.
  - key_s != key_state and counter == DEBOUNCE_CYCLES-1: key_state <= key_s and counter cleared.
  - Otherwise: counter increments.
- Any glitch back to the current key_state restarts the count from zero. Bursts shorter than DEBOUNCE_CYCLES cycles never change key_state.
- key_en and key_rel are registered. key_en = 1 for exactly the one cycle in which key_state goes 0->1; key_rel = 1 for exactly the one cycle in which key_state goes 1->0. They are never high together.
- Latency: if the pin is stable from edge k (edge k is the first edge sampling the new level), key_state and the pulse change at edge k+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges including edge k.
- Holding the key produces no further key_en unless the optional feature is compiled in.
- Reset asserted mid-count discards the partial count. After release of reset, a pin already held pressed needs a full debounce and then produces one key_en.

Optional Feature:
- Macro KEY_PROCESS_REPEAT_EN.
- Defined:
  - While key_state = 1, a repeat counter runs from the press pulse.
  - key_en pulses again REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - The repeat counter is cleared when key_state = 0 or on reset.
- Undefined: the repeat logic is absent, REPEAT_* are ignored, and there is exactly one key_en per press.

Decomposition:
- Package key_process_pkg holds:
  - the counter-width helper function (clog2-based);
  - a localparam for the synchronizer depth (2).
- One sub-module, key_sync: a parameterizable N-flop synchronizer with a reset value input parameter. It is instantiated once for key.

Test Plan:
- Defaults; after reset, 30 toggles of key (low 1.3 cycles / high 1.2 cycles) then key = 1 held for 400 cycles -> no key_en during the burst; exactly one key_en, 102 edges after the last edge sampling key = 0; key_state = 1.
- Then key = 0 held for 200 cycles -> one key_rel, 102 edges after release; no key_en; key_state = 0.
- key high for 99 cycles then low -> no pulse and key_state stays 0. key high for 100 cycles -> pulse.
- rst_n low for 3 cycles with the counter at 60 while key is held high -> no pulse at the original time; key_en appears 102 edges after rst_n returns high.
- KEY_ACTIVE = 0, key driven low for 300 cycles -> one key_en and key_state = 1. key high again -> one key_rel.
- With KEY_PROCESS_REPEAT_EN, REPEAT_DELAY = 50, REPEAT_PERIOD = 20, key held 200 cycles after the press pulse -> key_en at +0, +50, +70, +90 ... +190; no further pulses after release.
